// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencer.
// FSM state encoding, flush counter width and the hold/flush strobe bundle.
package pipe_ctrl_pkg;

    localparam int PCTRL_CNT_W = 3;
    localparam int REG_IDX_W   = 5;

    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'd0,
        PCTRL_FLUSH = 2'd1,
        PCTRL_BUSY  = 2'd2,
        PCTRL_LDUSE = 2'd3
    } pctrl_state_e;

    // Bundle of per-stage strobes, MSB first in port order.
    typedef struct packed {
        logic hold_if;
        logic hold_id;
        logic hold_ex;
        logic hold_mem;
        logic flush_id;
        logic flush_ex;
    } pctrl_ctl_t;

    localparam pctrl_ctl_t CTL_IDLE       = pctrl_ctl_t'(6'b000000);
    localparam pctrl_ctl_t CTL_HOLD_ALL   = pctrl_ctl_t'(6'b111100);
    localparam pctrl_ctl_t CTL_FLUSH_BOTH = pctrl_ctl_t'(6'b000011);
    localparam pctrl_ctl_t CTL_LOAD_USE   = pctrl_ctl_t'(6'b110001);

    // Counter value loaded on a taken jump: the jump cycle itself is the
    // first bubble, so the FLUSH state covers the remaining ones.
    function automatic logic [PCTRL_CNT_W-1:0] flush_load(input int flush_cycles);
        return PCTRL_CNT_W'(flush_cycles - 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// pipe_ctrl_load_use_detect: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a hazard).
module pipe_ctrl_load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 ex_load_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_use_i,
    input  logic                 id_rs2_use_i,
    output logic                 lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Per-operand match, then qualify with a real load to a non-zero rd.
    always_comb begin
        rs1_hit = id_rs1_use_i && (id_rs1_i == ex_rd_i);
        rs2_hit = id_rs2_use_i && (id_rs2_i == ex_rd_i);
        lu_o    = ex_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard-aware hold/flush sequencer for the five-stage core.
// Priority is mem_busy > jump_flag > load-use. Strobes are a Mealy function
// of the registered state and the current inputs, forced low during reset.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_flag,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_use,
    input  logic                 id_rs2_use,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_load,
    input  logic                 mem_busy,
    output logic                 hold_if,
    output logic                 hold_id,
    output logic                 hold_ex,
    output logic                 hold_mem,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic [1:0]           state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    pctrl_state_e           state_q, state_d;
    logic [PCTRL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    pctrl_ctl_t             ctl;
    pctrl_ctl_t             ctl_out;
    logic                   lu;

    // With a single bubble the jump cycle is the whole flush.
    localparam pctrl_state_e JUMP_NEXT = (FLUSH_CYCLES == 1) ? PCTRL_RUN : PCTRL_FLUSH;

    pipe_ctrl_load_use_detect u_lu (
        .ex_load_i    (ex_load),
        .ex_rd_i      (ex_rd),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_rs1_use_i (id_rs1_use),
        .id_rs2_use_i (id_rs2_use),
        .lu_o         (lu)
    );

    // Next-state and strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ctl     = CTL_IDLE;
        case (state_q)
            PCTRL_RUN, PCTRL_LDUSE: begin
                if (mem_busy) begin
                    ctl     = CTL_HOLD_ALL;
                    pend_d  = jump_flag;
                    state_d = PCTRL_BUSY;
                end else if (jump_flag) begin
                    ctl     = CTL_FLUSH_BOTH;
                    cnt_d   = flush_load(FLUSH_CYCLES);
                    state_d = JUMP_NEXT;
                end else if (lu && (state_q == PCTRL_RUN)) begin
                    // The bubble just inserted cannot re-trigger the same hazard.
                    ctl     = CTL_LOAD_USE;
                    state_d = PCTRL_LDUSE;
                end else begin
                    state_d = PCTRL_RUN;
                end
            end
            PCTRL_FLUSH: begin
                // EX holds a bubble here, so jump_flag is meaningless.
                if (mem_busy) begin
                    ctl = pctrl_ctl_t'(CTL_HOLD_ALL | CTL_FLUSH_BOTH);
                end else begin
                    ctl = CTL_FLUSH_BOTH;
                    if (cnt_q <= PCTRL_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = PCTRL_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            PCTRL_BUSY: begin
                if (mem_busy) begin
                    ctl    = CTL_HOLD_ALL;
                    pend_d = pend_q | jump_flag;
                end else if (pend_q) begin
                    ctl     = CTL_FLUSH_BOTH;
                    cnt_d   = flush_load(FLUSH_CYCLES);
                    pend_d  = 1'b0;
                    state_d = JUMP_NEXT;
                end else begin
                    state_d = PCTRL_RUN;
                end
            end
            default: begin
                state_d = PCTRL_RUN;
            end
        endcase
    end

    // State, flush counter and deferred-jump registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PCTRL_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Strobes are quiet for as long as reset is asserted.
    always_comb begin
        ctl_out = rst ? CTL_IDLE : ctl;
    end

    assign hold_if  = ctl_out.hold_if;
    assign hold_id  = ctl_out.hold_id;
    assign hold_ex  = ctl_out.hold_ex;
    assign hold_mem = ctl_out.hold_mem;
    assign flush_id = ctl_out.flush_id;
    assign flush_ex = ctl_out.flush_ex;
    assign state_o  = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctl_out.hold_if || ctl_out.hold_id || ctl_out.hold_ex || ctl_out.hold_mem) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctl_out.flush_id) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
